// File: rtl/multi_cycle_controller.sv
// ============================================================================
// Module   : multi_cycle_controller
// Purpose  : Multi-cycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB) with a
//            memory-wait timeout. Optional instruction counter: PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_cycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             r_type,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             reg_write2,
  output logic             mem_read,
  output logic             mem_write,
  output logic             j,
  output logic             jal,
  output logic             beq,
  output logic             bne,
  output logic             ori,
  output logic             lui,
  output logic             pc_write,
  output logic             ir_write,
  output logic [1:0]       alu_op,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic             bus_error
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] c_op_r    = 6'b000000;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [5:0] c_op_beq  = 6'b000100;
  localparam logic [5:0] c_op_bne  = 6'b000101;
  localparam logic [5:0] c_op_j    = 6'b000010;
  localparam logic [5:0] c_op_jal  = 6'b000011;
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_op_ori  = 6'b001101;
  localparam logic [5:0] c_op_lui  = 6'b001111;

  localparam logic [TO_W-1:0] c_to_last = TO_W'(MEM_TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [5:0]      r_op;
  logic [TO_W-1:0] r_wait;

  logic [5:0] w_op;
  logic       w_is_r, w_is_lw, w_is_sw, w_is_beq, w_is_bne;
  logic       w_is_j, w_is_jal, w_is_addi, w_is_ori, w_is_lui;
  logic       w_waiting, w_timeout;

  // DECODE must branch on the opcode being latched this cycle, not the old op_q
  assign w_op      = (r_state == S_DECODE) ? opcode : r_op;
  assign w_is_r    = (w_op == c_op_r);
  assign w_is_lw   = (w_op == c_op_lw);
  assign w_is_sw   = (w_op == c_op_sw);
  assign w_is_beq  = (w_op == c_op_beq);
  assign w_is_bne  = (w_op == c_op_bne);
  assign w_is_j    = (w_op == c_op_j);
  assign w_is_jal  = (w_op == c_op_jal);
  assign w_is_addi = (w_op == c_op_addi);
  assign w_is_ori  = (w_op == c_op_ori);
  assign w_is_lui  = (w_op == c_op_lui);

  // A ready strobe in the final wait cycle wins over the timeout
  assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timeout = w_waiting && !mem_ready && (r_wait == c_to_last);

  assign state = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_op    <= 6'd0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_op <= opcode;
      if ((w_next != r_state) || w_timeout)
        r_wait <= '0;
      else if (w_waiting && !mem_ready)
        r_wait <= r_wait + 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    r_type     = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    reg_write2 = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    j          = 1'b0;
    jal        = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    ori        = 1'b0;
    lui        = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_error  = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          mem_read = 1'b1;
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          bus_error = 1'b1;
          w_next    = S_FETCH;
        end else begin
          mem_read = 1'b1;
        end
      end

      S_DECODE: begin
        if (w_is_j) begin
          pc_write   = 1'b1;
          j          = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end else if (w_is_jal) begin
          pc_write   = 1'b1;
          jal        = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end else if (w_is_r || w_is_lw || w_is_sw || w_is_beq || w_is_bne ||
                     w_is_addi || w_is_ori || w_is_lui) begin
          w_next = S_EXEC;
        end else begin
          illegal = 1'b1;
          w_next  = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_src = w_is_lw || w_is_sw || w_is_addi || w_is_ori || w_is_lui;
        if (w_is_r)
          alu_op = 2'b11;
        else if (w_is_ori)
          alu_op = 2'b10;
        else if (w_is_beq || w_is_bne)
          alu_op = 2'b01;
        else
          alu_op = 2'b00;

        if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else if (w_is_beq || w_is_bne) begin
          beq        = w_is_beq;
          bne        = w_is_bne;
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end else begin
          w_next = S_WB;
        end
      end

      S_MEM: begin
        if (mem_ready) begin
          if (w_is_lw) begin
            mem_read = 1'b1;
            w_next   = S_WB;
          end else begin
            mem_write  = w_is_sw;
            instr_done = w_is_sw;
            w_next     = S_FETCH;
          end
        end else if (w_timeout) begin
          bus_error = 1'b1;
          w_next    = S_FETCH;
        end else begin
          mem_read  = w_is_lw;
          mem_write = w_is_sw;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = w_is_lw;
        r_type     = w_is_r;
        reg_write2 = w_is_r;
        ori        = w_is_ori;
        lui        = w_is_lui;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end

      default: w_next = S_FETCH;
    endcase

    // Strobes stay quiet while reset is held, independent of the clock
    if (rst) begin
      instr_done = 1'b0;
      illegal    = 1'b0;
      bus_error  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (instr_done)
      r_count <= r_count + 1'b1;
  end

  assign instr_count = r_count;
`endif

endmodule

`default_nettype wire
